// File: rtl/theremin_pkg.sv
// Shared sizing helpers and default gate constants for the theremin measurement and NCO blocks.
package theremin_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int GATE_CYCLES_DEF = 50000;

  function automatic int ch_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  function automatic int delta_w(input int cnt_w);
    return cnt_w + 1;
  endfunction

  function automatic int gate_w(input int gate_cycles);
    return (gate_cycles > 2) ? $clog2(gate_cycles) : 1;
  endfunction

endpackage

// File: rtl/theremin_freq_ch.sv
// One measurement channel: synchroniser, edge detect, saturating edge counter, sticky ovf,
// trimmable offset and the published count/delta/ovf registers, all updated on the latch strobe.
module theremin_freq_ch
  import theremin_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TUNE_STEP   = 1,
  parameter int OFFSET_INIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             square_in,
  input  logic             latch,
  input  logic             tune_inc,
  input  logic             tune_dec,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W:0]   delta_o,
  output logic             ovf_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] STEP    = CNT_W'(TUNE_STEP);

  logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, off_q, off_d, count_q, count_d;
  logic [CNT_W:0]   delta_q, delta_d, off_sum;
  logic             ovf_run_q, ovf_run_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_next;
  logic             edge_det, ovf_next;

  always_comb begin
    sync1_d  = square_in;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    edge_det = sync2_q & ~prev_q;

    cnt_next = cnt_q;
    if (edge_det && (cnt_q != CNT_MAX)) cnt_next = cnt_q + CNT_W'(1);
    ovf_next = ovf_run_q | (cnt_next == CNT_MAX);

    // The latch cycle's own edge lands in the published count; the running counter restarts.
    cnt_d     = latch ? '0 : cnt_next;
    ovf_run_d = latch ? 1'b0 : ovf_next;
    count_d   = latch ? cnt_next : count_q;
    ovf_d     = latch ? ovf_next : ovf_q;
    delta_d   = latch ? ({1'b0, cnt_next} - {1'b0, off_q}) : delta_q;

    off_sum = {1'b0, off_q} + {1'b0, STEP};
    off_d   = off_q;
    if (tune_inc)      off_d = off_sum[CNT_W] ? CNT_MAX : off_sum[CNT_W-1:0];
    else if (tune_dec) off_d = (off_q < STEP) ? '0 : off_q - STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      ovf_run_q <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      delta_q   <= '0;
      off_q     <= CNT_W'(OFFSET_INIT);
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      ovf_run_q <= ovf_run_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      delta_q   <= delta_d;
      off_q     <= off_d;
    end
  end

  assign count_o = count_q;
  assign delta_o = delta_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/theremin_freq_meter.sv
// Multi-channel gate-time frequency meter: counts square-wave edges per fixed gate window and
// publishes counts, offset-relative deltas and overflow flags one cycle after each terminal count.
module theremin_freq_meter
  import theremin_pkg::*;
#(
  parameter int  N_CH        = 2,
  parameter int  CNT_W       = CNT_W_DEF,
  parameter int  GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int  TUNE_STEP   = 1,
  parameter int  OFFSET_INIT = 0,
  localparam int CH_W        = ch_w(N_CH),
  localparam int DLT_W       = delta_w(CNT_W)
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [N_CH-1:0]       square_in,
  input  logic                  tune_up,
  input  logic                  tune_down,
  input  logic [CH_W-1:0]       tune_sel,
  output logic [N_CH*CNT_W-1:0] meas_count,
  output logic [N_CH*DLT_W-1:0] meas_delta,
  output logic [N_CH-1:0]       meas_ovf,
  output logic                  meas_valid
);
  localparam int                GATE_W    = gate_w(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic [GATE_W-1:0] gate_q, gate_d;
  logic              valid_q, valid_d;
  logic              gate_end;
  logic [N_CH-1:0]   inc_en, dec_en;

  always_comb begin
    gate_end = (gate_q == GATE_LAST);
    gate_d   = gate_end ? '0 : gate_q + GATE_W'(1);
    valid_d  = gate_end;
    // Out-of-range selects match no channel, so those pulses fall away here.
    for (int i = 0; i < N_CH; i++) begin
      inc_en[i] = tune_up && !tune_down && (int'(tune_sel) == i);
      dec_en[i] = tune_down && !tune_up && (int'(tune_sel) == i);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      gate_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      gate_q  <= gate_d;
      valid_q <= valid_d;
    end
  end

  assign meas_valid = valid_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    theremin_freq_ch #(
      .CNT_W      (CNT_W),
      .TUNE_STEP  (TUNE_STEP),
      .OFFSET_INIT(OFFSET_INIT)
    ) u_ch (
      .clk      (clk_clk),
      .rst_n    (reset_reset_n),
      .square_in(square_in[i]),
      .latch    (gate_end),
      .tune_inc (inc_en[i]),
      .tune_dec (dec_en[i]),
      .count_o  (meas_count[i*CNT_W +: CNT_W]),
      .delta_o  (meas_delta[i*DLT_W +: DLT_W]),
      .ovf_o    (meas_ovf[i])
    );
  end

endmodule

// File: tb/tb_theremin_freq_meter.sv
// Randomised square-wave stimulus against an edge-timestamp reference model of the gate meter.
module tb_theremin_freq_meter;
  localparam int N_CH = 3;
  localparam int CW   = 6;
  localparam int DW   = CW + 1;
  localparam int G    = 400;
  localparam int STEP = 4;
  localparam int MAXV = (1 << CW) - 1;
  localparam int CHW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic [N_CH-1:0]      square_in;
  logic                 tune_up, tune_down;
  logic [CHW-1:0]       tune_sel;
  logic [N_CH*CW-1:0]   meas_count;
  logic [N_CH*DW-1:0]   meas_delta;
  logic [N_CH-1:0]      meas_ovf;
  logic                 meas_valid;

  int total = 0;
  int bad   = 0;

  int per[N_CH];
  int ph[N_CH];
  int off[N_CH];
  int edge_no = 0;
  int gates   = 0;
  int cap_q[$];
  logic [N_CH-1:0]    prev_lvl;
  logic [N_CH*DW-1:0] exp_delta_vec;
  logic [N_CH*CW-1:0] exp_count_vec;

  theremin_freq_meter #(
    .N_CH(N_CH), .CNT_W(CW), .GATE_CYCLES(G), .TUNE_STEP(STEP), .OFFSET_INIT(0)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .square_in    (square_in),
    .tune_up      (tune_up),
    .tune_down    (tune_down),
    .tune_sel     (tune_sel),
    .meas_count   (meas_count),
    .meas_delta   (meas_delta),
    .meas_ovf     (meas_ovf),
    .meas_valid   (meas_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: timestamp every rising edge as first seen at a clock edge.
  initial begin
    prev_lvl = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        edge_no  = 0;
        prev_lvl = '0;
        cap_q.delete();
      end else begin
        edge_no++;
        for (int c = 0; c < N_CH; c++)
          if (square_in[c] && !prev_lvl[c]) cap_q.push_back(edge_no * 4 + c);
        prev_lvl = square_in;
      end
    end
  end

  initial begin
    square_in = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < N_CH; c++) begin
        if (per[c] < 2) square_in[c] = 1'b0;
        else begin
          ph[c] = (ph[c] + 1) % per[c];
          square_in[c] = (ph[c] < per[c] / 2);
        end
      end
    end
  end

  // A captured rise is counted two edges later; gate n owns counted edges in ((n-1)G, nG].
  function automatic int cap_count(input int ch, input int n);
    int c;
    int e;
    c = 0;
    foreach (cap_q[k]) begin
      e = cap_q[k] / 4 + 2;
      if ((cap_q[k] % 4) == ch && e > (n - 1) * G && e <= n * G) c++;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_count"}, 32'(meas_count), 0);
    chk({tag, "_delta"}, 32'(meas_delta), 0);
    chk({tag, "_ovf"},   32'(meas_ovf),   0);
    chk({tag, "_valid"}, 32'(meas_valid), 0);
  endtask

  task automatic run_gate();
    bit seen;
    int n;
    int ec;
    logic [DW-1:0] d;
    seen = 0;
    for (int i = 0; i < G + 20; i++) begin
      @(negedge clk);
      if (meas_valid) begin
        seen = 1;
        break;
      end
    end
    gates++;
    chk("valid_seen", 32'(seen), 1);
    if (seen) begin
      chk("valid_time", edge_no, gates * G);
      n = gates;
      for (int c = 0; c < N_CH; c++) begin
        ec = cap_count(c, n);
        if (ec > MAXV) ec = MAXV;
        d = DW'(ec) - DW'(off[c]);
        exp_count_vec[c*CW +: CW] = CW'(ec);
        exp_delta_vec[c*DW +: DW] = d;
        chk($sformatf("count_ch%0d_g%0d", c, n), 32'(meas_count[c*CW +: CW]), ec);
        chk($sformatf("delta_ch%0d_g%0d", c, n), 32'(meas_delta[c*DW +: DW]), 32'(d));
        chk($sformatf("ovf_ch%0d_g%0d", c, n), 32'(meas_ovf[c]), 32'(cap_count(c, n) >= MAXV));
      end
      @(negedge clk);
      chk("valid_width", 32'(meas_valid), 0);
    end
  endtask

  task automatic tune(input logic up, input logic dn, input int sel);
    @(posedge clk);
    #1;
    tune_up   = up;
    tune_down = dn;
    tune_sel  = CHW'(sel);
    @(posedge clk);
    #1;
    tune_up   = 1'b0;
    tune_down = 1'b0;
    if (sel < N_CH) begin
      if (up && !dn)      off[sel] = (off[sel] + STEP > MAXV) ? MAXV : off[sel] + STEP;
      else if (dn && !up) off[sel] = (off[sel] < STEP) ? 0 : off[sel] - STEP;
    end
  endtask

  task automatic check_hold(input string tag);
    chk({tag, "_count"}, 32'(meas_count), 32'(exp_count_vec));
    chk({tag, "_delta"}, 32'(meas_delta), 32'(exp_delta_vec));
  endtask

  initial begin
    rst_n = 1'b0;
    tune_up = 1'b0;
    tune_down = 1'b0;
    tune_sel = '0;
    for (int c = 0; c < N_CH; c++) begin
      per[c] = $urandom_range(3, 9);
      ph[c]  = $urandom_range(0, 20);
      off[c] = 0;
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    per[0] = 10; per[1] = 25; per[2] = 7;
    run_gate();
    run_gate();

    repeat (3) begin
      for (int c = 0; c < N_CH; c++) per[c] = $urandom_range(6, 50);
      run_gate();
    end

    per[0] = 4;
    run_gate();
    per[0] = 20;
    run_gate();
    run_gate();

    per[1] = 25;
    repeat (5) tune(1'b1, 1'b0, 1);
    check_hold("tune_no_recalc");
    run_gate();
    repeat (10) tune(1'b0, 1'b1, 1);
    run_gate();
    per[2] = 30;
    repeat (17) tune(1'b1, 1'b0, 2);
    run_gate();
    tune(1'b1, 1'b1, 2);
    tune(1'b1, 1'b0, 3);
    tune(1'b0, 1'b1, 3);
    check_hold("tune_ignored");
    run_gate();

    repeat (200) @(posedge clk);
    #1 rst_n = 1'b0;
    gates = 0;
    for (int c = 0; c < N_CH; c++) off[c] = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_zero("mid_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_gate();
    run_gate();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
